ultrasonic_echo_emulator: RTL and testbench
===========================================

Name: ultrasonic_echo_emulator

Overview:
Behavioural responder for the HC-SR04-style trig/echo protocol, i.e. the sensor side of proximity_sensor. It accepts a trig pulse, waits a fixed acoustic burst time, then drives echo high for a programmed number of clock cycles. A no-object timeout and a post-echo guard interval are enforced. It serves as on-board hardware-in-the-loop stand-in for the physical sensor and as the bench model for proximity_sensor.

Parameters:
W, 22, width of echo_cycles (matches distanceRAW)
MIN_TRIG_CYC, 500, minimum accepted trig high width in clk cycles (10 us at 50 MHz)
BURST_CYC, 10000, trig-fall to echo-rise delay (200 us, 8x40 kHz burst)
TIMEOUT_CYC, 1900000, maximum echo width (38 ms no-object pulse)
GUARD_CYC, 500000, post-echo dead time before next trig is accepted (10 ms)

Ports:
clk  input  1  system clock (CLOCK_50)
rst_n  input  1  asynchronous active-low reset
trig  input  1  trigger from initiator; asynchronous, synchronised internally
enable  input  1  0 = ignore new triggers; an in-flight measurement still completes
echo_cycles  input  W  desired echo high width in clk cycles; sampled at trig acceptance
echo  output  1  echo pulse to initiator, registered
busy  output  1  high in every state except IDLE
trig_short  output  1  one-cycle pulse when a trig shorter than MIN_TRIG_CYC is rejected

Behaviour:
- Reset (async assert, sync deassert of state): state=IDLE, echo=0, busy=0, trig_short=0, counters=0, synchroniser flops=0.
- trig passes a 2-flop synchroniser -> trig_s. trig_s_d is a 1-cycle delayed copy used for edge detection. All timing below is relative to trig_s.
- IDLE: on trig_s rising edge (trig_s=1, trig_s_d=0) with enable=1, go TRIG_HI, cnt=1. A trig already high on leaving GUARD is not accepted; a fresh rising edge is required.
- TRIG_HI: while trig_s=1, cnt++ (saturating at MIN_TRIG_CYC). On the first trig_s=0:
  - cnt>=MIN_TRIG_CYC: latch len=echo_cycles, clamped to [1, TIMEOUT_CYC] (0 -> 1, >TIMEOUT_CYC -> TIMEOUT_CYC); cnt=0; go BURST.
  - otherwise: trig_short=1 for that cycle, go IDLE.
  - enable is not re-checked once TRIG_HI is entered.
- BURST: cnt counts 0..BURST_CYC-1, then go ECHO with echo=1 registered. echo rises exactly BURST_CYC+1 clk edges after the edge that samples trig_s=0.
- ECHO: echo held high exactly len cycles, then echo=0, cnt=0, go GUARD. trig activity is ignored.
- GUARD: GUARD_CYC cycles with trig ignored, then IDLE. busy falls on entry to IDLE.
- End-to-end: input trig falling to echo rising = 2 (sync) + BURST_CYC + 1 cycles.
- enable deasserted mid-measurement has no effect until IDLE.
- Reset mid-operation: echo drops immediately (async); no partial pulse resumes.
- All counters are sized $clog2 of the largest of TIMEOUT_CYC, BURST_CYC and GUARD_CYC, plus 1. No wrap is possible.

Optional Feature:
ECHO_JITTER_EN: when defined, an 8-bit maximal LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advances once per accepted trigger. Its value (0..255) is added to len before the TIMEOUT_CYC clamp, modelling acoustic jitter. When not defined, echo width equals the clamped echo_cycles exactly and no LFSR logic exists.

Decomposition:
- Package ultrasonic_pkg: state enum (IDLE, TRIG_HI, BURST, ECHO, GUARD); default timing constants; LFSR seed and taps.
- Sub-module sync_2ff (1-bit, async active-low reset), reusable for the echo input of proximity_sensor.
- FSM and counters stay in one always_ff.

Test Plan (MIN_TRIG_CYC=4, BURST_CYC=8, GUARD_CYC=6, TIMEOUT_CYC=100, W=22):
- trig high 5 cycles, echo_cycles=20 -> echo rises 11 cycles after trig falls, stays high exactly 20 cycles; busy low 6 cycles after echo falls.
- trig high 3 cycles -> trig_short single pulse, echo stays 0, busy returns to 0.
- echo_cycles=500, then echo_cycles=0 on two separate triggers -> echo widths 100 and 1.
- Second trig pulse during ECHO and during GUARD -> ignored; held high across GUARD end -> still no acceptance until a new rising edge.
- enable=0 with a valid trig -> no response; enable dropped during BURST -> the measurement completes normally.
- rst_n asserted mid-ECHO -> echo=0 asynchronously; after release a valid trig yields a normal 11-cycle latency. With ECHO_JITTER_EN, echo width lies in [20,100] and differs across consecutive triggers.

Source files
------------

// File: rtl/ultrasonic_echo_emulator_pkg.sv
// Shared types and default timing for the HC-SR04-style echo responder.
package ultrasonic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG_HI,
        BURST,
        ECHO,
        GUARD
    } state_t;

    localparam int DEF_W            = 22;
    localparam int DEF_MIN_TRIG_CYC = 500;
    localparam int DEF_BURST_CYC    = 10000;
    localparam int DEF_TIMEOUT_CYC  = 1900000;
    localparam int DEF_GUARD_CYC    = 500000;

    // Fibonacci LFSR for x^8+x^6+x^5+x^4+1: taps on bits 7,5,4,3
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ultrasonic_echo_emulator_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ultrasonic_echo_emulator.sv
// Sensor-side trig/echo responder: trig width check, burst delay, echo pulse, guard time.
// Optional macro ECHO_JITTER_EN adds LFSR-based jitter to the echo width.
module ultrasonic_echo_emulator
    import ultrasonic_pkg::*;
#(
    parameter int W            = DEF_W,
    parameter int MIN_TRIG_CYC = DEF_MIN_TRIG_CYC,
    parameter int BURST_CYC    = DEF_BURST_CYC,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter int GUARD_CYC    = DEF_GUARD_CYC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         trig,
    input  logic         enable,
    input  logic [W-1:0] echo_cycles,
    output logic         echo,
    output logic         busy,
    output logic         trig_short
);

    localparam int MAX_AB  = (TIMEOUT_CYC > BURST_CYC) ? TIMEOUT_CYC : BURST_CYC;
    localparam int MAX_CYC = (MAX_AB > GUARD_CYC) ? MAX_AB : GUARD_CYC;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam int SW      = ((W > CW) ? W : CW) + 1;

    localparam logic [CW-1:0] MIN_C      = CW'(MIN_TRIG_CYC);
    localparam logic [CW-1:0] BURST_LAST = CW'(BURST_CYC - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_C  = CW'(TIMEOUT_CYC);
    localparam logic [CW-1:0] ONE_C      = CW'(1);
    localparam logic [SW-1:0] TIMEOUT_S  = SW'(TIMEOUT_CYC);

    logic          trig_s;
    logic          trig_s_d;
    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [CW-1:0] len, len_nx;
    logic          echo_nx;
    logic          short_nx;
    logic [SW-1:0] len_req;
    logic [CW-1:0] len_clamped;

    sync_2ff u_trig_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (trig),
        .q     (trig_s)
    );

`ifdef ECHO_JITTER_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if ((state == TRIG_HI) && !trig_s && (cnt >= MIN_C)) begin
            lfsr <= lfsr_next(lfsr);
        end
    end

    assign len_req = SW'(echo_cycles) + SW'(lfsr);
`else
    assign len_req = SW'(echo_cycles);
`endif

    always_comb begin
        if (len_req == '0) begin
            len_clamped = ONE_C;
        end else if (len_req > TIMEOUT_S) begin
            len_clamped = TIMEOUT_C;
        end else begin
            len_clamped = len_req[CW-1:0];
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        len_nx   = len;
        echo_nx  = echo;
        short_nx = 1'b0;
        case (state)
            IDLE: begin
                if (trig_s && !trig_s_d && enable) begin
                    state_nx = TRIG_HI;
                    cnt_nx   = ONE_C;
                end
            end
            TRIG_HI: begin
                if (trig_s) begin
                    if (cnt < MIN_C) begin
                        cnt_nx = cnt + 1'b1;
                    end
                end else if (cnt >= MIN_C) begin
                    len_nx   = len_clamped;
                    cnt_nx   = '0;
                    state_nx = BURST;
                end else begin
                    short_nx = 1'b1;
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
            end
            BURST: begin
                // ECHO is entered with cnt=1 so that cnt==len marks the last high cycle
                if (cnt == BURST_LAST) begin
                    state_nx = ECHO;
                    echo_nx  = 1'b1;
                    cnt_nx   = ONE_C;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            ECHO: begin
                if (cnt == len) begin
                    echo_nx  = 1'b0;
                    cnt_nx   = '0;
                    state_nx = GUARD;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            GUARD: begin
                if (cnt == GUARD_LAST) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                cnt_nx   = '0;
                echo_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // Next-state logic is combinational; all FSM and counter state is registered here together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            len        <= '0;
            echo       <= 1'b0;
            trig_short <= 1'b0;
            trig_s_d   <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            len        <= len_nx;
            echo       <= echo_nx;
            trig_short <= short_nx;
            trig_s_d   <= trig_s;
        end
    end

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Randomised and directed bench for ultrasonic_echo_emulator with a protocol-level reference model.
module tb_ultrasonic_echo_emulator;

    localparam int W       = 22;
    localparam int MIN     = 4;
    localparam int BURST   = 8;
    localparam int GUARD   = 6;
    localparam int TIMEOUT = 100;
    localparam int LAT     = 2 + BURST + 1;
    localparam int BUDGET  = 400;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         trig;
    logic         enable;
    logic [W-1:0] echo_cycles;
    logic         echo;
    logic         busy;
    logic         trig_short;

    int total = 0;
    int bad   = 0;

    int m_rise, m_fall, m_idle, m_short, m_done;

    always #5 clk = ~clk;

    ultrasonic_echo_emulator #(
        .W            (W),
        .MIN_TRIG_CYC (MIN),
        .BURST_CYC    (BURST),
        .TIMEOUT_CYC  (TIMEOUT),
        .GUARD_CYC    (GUARD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .trig        (trig),
        .enable      (enable),
        .echo_cycles (echo_cycles),
        .echo        (echo),
        .busy        (busy),
        .trig_short  (trig_short)
    );

    function automatic int clamp_len(input int ec);
        if (ec <= 0) return 1;
        if (ec > TIMEOUT) return TIMEOUT;
        return ec;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_width(input string tag, input int ec, input int w);
`ifdef ECHO_JITTER_EN
        int lo, hi;
        lo = clamp_len(ec);
        hi = clamp_len(ec + 255);
        total++;
        assert (w >= lo && w <= hi) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=[%0d,%0d]", tag, w, lo, hi);
        end
`else
        chk(tag, w, clamp_len(ec));
`endif
    endtask

    // mode 0: plain; 1: retrigger in ECHO and hold trig high across GUARD end;
    // 2: drop enable and change echo_cycles during BURST
    task automatic run_trig(input int hi, input int ec, input logic en, input int mode);
        int t;
        m_rise = -1; m_fall = -1; m_idle = -1; m_short = 0; m_done = 0;
        @(posedge clk); #1;
        echo_cycles = W'(ec);
        enable      = en;
        trig        = 1'b1;
        repeat (hi) @(posedge clk);
        #1 trig = 1'b0;
        t = 0;
        while (t < BUDGET && m_done == 0) begin
            @(posedge clk); #1;
            t++;
            if (trig_short) m_short++;
            if (echo && m_rise < 0) m_rise = t;
            if (!echo && m_rise >= 0 && m_fall < 0) m_fall = t;
            if (mode == 1) begin
                if (t == 14) trig = 1'b1;
                if (t == 19) trig = 1'b0;
                if (m_fall >= 0 && t == m_fall + 1) trig = 1'b1;
            end
            if (mode == 2 && t == 5) begin
                enable      = 1'b0;
                echo_cycles = W'(7);
            end
            if (t >= 3 && !busy && !echo) begin
                m_idle = t;
                m_done = 1;
            end
        end
        chk("budget", m_done, 1);
    endtask

    task automatic expect_run(input string tag, input int hi, input int ec, input logic en);
        logic acc;
        acc = en && (hi >= MIN);
        chk({tag, "_short"}, m_short, (en && hi < MIN) ? 1 : 0);
        if (acc) begin
            chk({tag, "_lat"}, m_rise, LAT);
            chk_width({tag, "_width"}, ec, m_fall - m_rise);
            chk({tag, "_guard"}, m_idle - m_fall, GUARD);
        end else begin
            chk({tag, "_noecho"}, m_rise, -1);
        end
    endtask

    initial begin
        int hi, ec, sel;
        logic en;

        rst_n       = 1'b0;
        trig        = 1'b0;
        enable      = 1'b0;
        echo_cycles = '0;
        #23;
        chk("rst_echo", echo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_short", trig_short, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);

        run_trig(5, 20, 1'b1, 0);
        expect_run("basic", 5, 20, 1'b1);

        run_trig(3, 20, 1'b1, 0);
        expect_run("short3", 3, 20, 1'b1);
        chk("short3_busy", busy, 0);

        run_trig(4, 33, 1'b1, 0);
        expect_run("min4", 4, 33, 1'b1);

        run_trig(5, 500, 1'b1, 0);
        expect_run("clamp_hi", 5, 500, 1'b1);
        run_trig(5, 0, 1'b1, 0);
        expect_run("clamp_lo", 5, 0, 1'b1);

        run_trig(5, 20, 1'b1, 1);
        expect_run("retrig", 5, 20, 1'b1);
        repeat (10) @(posedge clk);
        #1 chk("held_no_accept", busy, 0);
        trig = 1'b0;
        repeat (4) @(posedge clk);

        run_trig(6, 20, 1'b0, 0);
        expect_run("disabled", 6, 20, 1'b0);

        run_trig(5, 25, 1'b1, 2);
        expect_run("en_drop", 5, 25, 1'b1);
        enable = 1'b1;

        @(posedge clk); #1;
        echo_cycles = W'(50);
        trig        = 1'b1;
        repeat (5) @(posedge clk);
        #1 trig = 1'b0;
        for (int i = 0; i < 30 && !echo; i++) begin
            @(posedge clk); #1;
        end
        chk("rst_pre_echo", echo, 1);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_async_echo", echo, 0);
        chk("rst_async_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1 chk("rst_no_resume", echo, 0);
        run_trig(5, 20, 1'b1, 0);
        expect_run("after_rst", 5, 20, 1'b1);

        for (int n = 0; n < 14; n++) begin
            hi  = $urandom_range(1, 7);
            sel = $urandom_range(0, 3);
            case (sel)
                0:       ec = 0;
                1:       ec = $urandom_range(1, 100);
                2:       ec = $urandom_range(101, 4000);
                default: ec = $urandom_range(1, 30);
            endcase
            en = ($urandom_range(0, 3) != 0);
            run_trig(hi, ec, en, 0);
            expect_run("rand", hi, ec, en);
            enable = 1'b1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
